// File: rtl/jk_bank_arbiter.sv
// Bank of JK flip-flop cells shared by NREQ requesters.
// A round-robin arbiter applies one granted {j,k} command per clock to the addressed cell.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     q,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  eligible;
  logic [PtrW-1:0]  win;
  logic             found;
  logic [PtrW:0]    cand;
  logic [1:0]       op_a  [NREQ];
  logic [IDXW-1:0]  idx_a [NREQ];
  logic [1:0]       sel_op;
  logic [IDXW-1:0]  sel_idx;
  logic             in_range;

  // A requester granted last cycle is excluded so it can drop req without a double grant.
  assign eligible = req & ~gnt_q;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = op[2*i +: 2];
      idx_a[i] = idx[IDXW*i +: IDXW];
    end
  end

  // Search ptr, ptr+1, ... modulo NREQ for the first eligible requester.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (cand >= (PtrW+1)'(NREQ)) begin
        cand = cand - (PtrW+1)'(NREQ);
      end
      if (!found && eligible[cand[PtrW-1:0]]) begin
        found = 1'b1;
        win   = cand[PtrW-1:0];
      end
    end
  end

  assign sel_op   = op_a[win];
  assign sel_idx  = idx_a[win];
  assign in_range = ({1'b0, sel_idx} < (IDXW+1)'(WIDTH));

  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    q_d   = q_q;
    err_d = 1'b0;
    if (found) begin
      gnt_d[win] = 1'b1;
      ptr_d      = (win == PtrW'(NREQ - 1)) ? '0 : win + 1'b1;
      if (in_range) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (sel_idx == IDXW'(c)) begin
            unique case (sel_op)
              2'b01:   q_d[c] = 1'b0;
              2'b10:   q_d[c] = 1'b1;
              2'b11:   q_d[c] = ~q_q[c];
              default: q_d[c] = q_q[c];
            endcase
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      gnt_q <= '0;
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign gnt  = gnt_q;
  assign q    = q_q;
  assign err  = err_q;
  assign busy = |req;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter (NREQ=4, WIDTH=6 so out-of-range indices are reachable).
module tb_jk_bank_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [5:0] q;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [11:0] idx;
  logic [3:0]  gnt;
  logic [5:0]  q;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  exp_t       sb[$];
  logic [5:0] m_q;
  logic [3:0] m_gnt;
  int         m_ptr;

  jk_bank_arbiter #(
    .NREQ (4),
    .WIDTH(6),
    .IDXW (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .op  (op),
    .idx (idx),
    .gnt (gnt),
    .q   (q),
    .err (err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_cmd(input int i, input logic [1:0] jk, input logic [2:0] c);
    op[2*i +: 2]  = jk;
    idx[3*i +: 3] = c;
  endtask

  // Predict the outcome of the coming edge from the present inputs, queue it, then clock.
  task automatic tick();
    exp_t       e;
    logic [3:0] elig;
    logic [2:0] c;
    logic [1:0] jk;
    int         w;
    int         p;
    e.err = 1'b0;
    if (!rst) begin
      m_q   = '0;
      m_gnt = '0;
      m_ptr = 0;
    end else begin
      elig = req & ~m_gnt;
      w    = -1;
      for (int k = 0; k < 4; k++) begin
        p = (m_ptr + k) % 4;
        if (w < 0 && elig[p] === 1'b1) w = p;
      end
      if (w < 0) begin
        m_gnt = '0;
      end else begin
        m_gnt = 4'(1 << w);
        m_ptr = (w + 1) % 4;
        c     = idx[3*w +: 3];
        jk    = op[2*w +: 2];
        if (c < 3'd6) begin
          case (jk)
            2'b01:   m_q[c] = 1'b0;
            2'b10:   m_q[c] = 1'b1;
            2'b11:   m_q[c] = ~m_q[c];
            default: ;
          endcase
        end else begin
          e.err = 1'b1;
        end
      end
    end
    e.gnt = m_gnt;
    e.q   = m_q;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b10, 3'(i));
    for (int n = 0; n < 2; n++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({gnt, q, err} !== {e.gnt, e.q, e.err} || {gnt, q, err} !== 11'd0) begin
        bad++;
        $display("FAIL reset%0d: gnt=%b q=%h err=%b, expected all zero", n, gnt, q, err);
      end
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy: got %b, expected 1", busy);
    end
    rst = 1'b1;
    tick();
    e = sb.pop_front();
    total++;
    if (gnt !== 4'b0001 || q !== 6'h01 || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
      bad++;
      $display("FAIL reset_first: gnt=%b q=%h, expected gnt=0001 q=01", gnt, q);
    end
  endtask

  task automatic test_single();
    exp_t       e;
    logic [1:0] ops [3];
    logic [5:0] qs  [3];
    ops[0] = 2'b10; ops[1] = 2'b11; ops[2] = 2'b00;
    qs[0]  = 6'h20; qs[1]  = 6'h00; qs[2]  = 6'h00;
    rst = 1'b0; req = '0; op = '0; idx = '0;
    tick();
    void'(sb.pop_front());
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      req = 4'b0100;
      set_cmd(2, ops[n], 3'd5);
      tick();
      e = sb.pop_front();
      total++;
      if (gnt !== 4'b0100 || q !== qs[n] || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
        bad++;
        $display("FAIL single%0d: gnt=%b q=%h err=%b, expected gnt=0100 q=%h err=0",
                 n, gnt, q, err, qs[n]);
      end
      req = '0;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL single_busy%0d: got %b, expected 0", n, busy);
      end
      tick();
      e = sb.pop_front();
      total++;
      if (gnt !== 4'b0000 || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
        bad++;
        $display("FAIL single_idle%0d: gnt=%b q=%h, expected gnt=0000 q=%h", n, gnt, q, e.q);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    rst = 1'b0; req = '0;
    tick();
    void'(sb.pop_front());
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b11, 3'(i));
    for (int n = 0; n < 8; n++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (gnt !== 4'(1 << (n % 4)) || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
        bad++;
        $display("FAIL rr%0d: gnt=%b q=%h, expected gnt=%b q=%h", n, gnt, q, 4'(1 << (n % 4)),
                 e.q);
      end
    end
    total++;
    if (q !== 6'h00) begin
      bad++;
      $display("FAIL rr_final: q=%h, expected 00", q);
    end
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [3:0] gs [4];
    gs[0] = 4'b0001; gs[1] = 4'b0010; gs[2] = 4'b0100; gs[3] = 4'b1000;
    rst = 1'b0; req = '0; op = '0; idx = '0;
    tick();
    void'(sb.pop_front());
    rst = 1'b1;
    req = 4'b0111;
    for (int n = 0; n < 3; n++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (gnt !== gs[n] || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
        bad++;
        $display("FAIL wrap_pre%0d: gnt=%b, expected %b", n, gnt, gs[n]);
      end
    end
    req = 4'b1001;
    for (int n = 0; n < 2; n++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (gnt !== gs[(n + 3) % 4] || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
        bad++;
        $display("FAIL wrap%0d: gnt=%b, expected %b", n, gnt, gs[(n + 3) % 4]);
      end
    end
    // Same cell from two requesters: the later grant decides q[2].
    rst = 1'b0; req = '0;
    tick();
    void'(sb.pop_front());
    rst = 1'b1;
    req = 4'b0011;
    set_cmd(0, 2'b10, 3'd2);
    set_cmd(1, 2'b01, 3'd2);
    for (int n = 0; n < 2; n++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (q[2] !== (n == 0) || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
        bad++;
        $display("FAIL conflict%0d: gnt=%b q=%h, expected gnt=%b q=%h", n, gnt, q, e.gnt, e.q);
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    rst = 1'b0; req = '0; op = '0; idx = '0;
    tick();
    void'(sb.pop_front());
    rst = 1'b1;
    req = 4'b0010;
    set_cmd(1, 2'b10, 3'd7);
    tick();
    e = sb.pop_front();
    total++;
    if (gnt !== 4'b0010 || err !== 1'b1 || q !== 6'h00 || {gnt, q, err} !== {e.gnt, e.q, e.err})
    begin
      bad++;
      $display("FAIL oor: gnt=%b q=%h err=%b, expected gnt=0010 q=00 err=1", gnt, q, err);
    end
    req = '0;
    tick();
    e = sb.pop_front();
    total++;
    if (err !== 1'b0 || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
      bad++;
      $display("FAIL oor_clear: err=%b gnt=%b, expected err=0 gnt=0000", err, gnt);
    end
    req = 4'b1111;
    set_cmd(1, 2'b00, 3'd0);
    tick();
    e = sb.pop_front();
    total++;
    if (gnt !== 4'b0100 || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
      bad++;
      $display("FAIL oor_ptr: gnt=%b, expected 0100", gnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    rst = 1'b0; req = '0; op = '0; idx = '0;
    tick();
    void'(sb.pop_front());
    rst = 1'b1;
    req = 4'b0011;
    set_cmd(0, 2'b10, 3'd0);
    set_cmd(1, 2'b10, 3'd1);
    tick();
    e = sb.pop_front();
    total++;
    if (gnt !== 4'b0001 || q !== 6'h01 || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
      bad++;
      $display("FAIL mid_pre: gnt=%b q=%h, expected gnt=0001 q=01", gnt, q);
    end
    rst = 1'b0;
    tick();
    e = sb.pop_front();
    total++;
    if ({gnt, q, err} !== 11'd0 || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
      bad++;
      $display("FAIL mid_rst: gnt=%b q=%h err=%b, expected all zero", gnt, q, err);
    end
    rst = 1'b1;
    tick();
    e = sb.pop_front();
    total++;
    if (gnt !== 4'b0001 || q !== 6'h01 || {gnt, q, err} !== {e.gnt, e.q, e.err}) begin
      bad++;
      $display("FAIL mid_post: gnt=%b q=%h, expected gnt=0001 q=01", gnt, q);
    end
  endtask

  initial begin
    rst = 1'b0; req = '0; op = '0; idx = '0;
    m_q = '0; m_gnt = '0; m_ptr = 0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
